id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline stage of the 5-stage RV32 core, directly downstream of the
//   decode-stage Control unit. Registers Control's outputs and ID operands for
//   EX. Owns load-use hazard detection: it stalls PC and IF/ID and inserts a bubble.
//   Gates the branch flush while stalled, and keeps saturating stall/bubble counters.
// PARAMETERS
//   XLEN    32  operand/immediate width
//   REG_AW  5   register address width
//   CNT_W   16  width of the performance counters
// PORTS
//   clk_i       in   1       clock, rising edge
//   rst_n_i     in   1       reset, asynchronous, active-low
//   valid_i     in   1       ID holds a real instruction
//   aluOp_i     in   2       from Control: 10 R-type, 01 I-type/beq, 00 ld/st
//   aluSrc_i    in   1       from Control: 1 = imm operand
//   wbDst_i     in   1       from Control
//   memRead_i   in   1       from Control
//   memWrite_i  in   1       from Control
//   memToReg_i  in   1       from Control
//   regWrite_i  in   1       from Control
//   flush_i     in   1       from Control: branch taken in ID
//   funct_i     in   10      {funct7,funct3}
//   rs1Data_i   in   XLEN    register-file read port 1
//   rs2Data_i   in   XLEN    register-file read port 2
//   imm_i       in   XLEN    sign-extended immediate
//   rs1Addr_i   in   REG_AW  rs1 index; rs1Used_i in 1: instruction reads rs1
//   rs2Addr_i   in   REG_AW  rs2 index; rs2Used_i in 1: instruction reads rs2
//   rdAddr_i    in   REG_AW  destination index
//   hold_i      in   1       downstream (MEM) freeze request
//   ex*_o       out  -       registered copies of every input above except
//                            flush/hold/rsXUsed: exAluOp_o .. exRdAddr_o
//   exValid_o   out  1       EX holds a real instruction
//   stall_o     out  1       hold PC and IF/ID (combinational)
//   flush_o     out  1       gated flush to IF/ID (combinational)
//   stallCnt_o  out  CNT_W   load-use stall cycles, saturating
//   bubbleCnt_o out  CNT_W   bubbles inserted, saturating
// BEHAVIOUR
//   - Reset (async, rst_n_i=0): all ex*_o, exValid_o and both counters go to 0.
//     This happens mid-operation too; there are no partial updates.
//   - Hazard (combinational): haz = exValid_o & exMemRead_o & exRdAddr_o!=0 &
//     valid_i & ((rs1Used_i & rs1Addr_i==exRdAddr_o) |
//     (rs2Used_i & rs2Addr_i==exRdAddr_o)).
//   - stall_o = haz | hold_i.  flush_o = flush_i & ~stall_o
//     (a branch resolved on stale load data must not redirect).
//   - Register update priority each edge:
//     hold_i   -> all ex*_o keep value (freeze; no bubble).
//     haz      -> bubble: exValid_o=0; exRegWrite/exMemRead/exMemWrite/
//                 exMemToReg=0; exAluOp=00; data fields don't-care (hold).
//     valid_i=0-> same bubble encoding.
//     else     -> load all inputs; exValid_o=1.
//   - Latency: 1 cycle ID->EX. A load-use pair costs exactly 1 bubble, because in
//     the next cycle the load has moved on and haz drops.
//   - Counters: stallCnt +1 on every cycle with haz & ~hold_i. bubbleCnt +1 on every
//     bubble loaded (haz or !valid_i, ~hold_i). Both saturate at 2^CNT_W-1 and
//     never wrap.
//   - Simultaneous haz & hold_i: hold wins, stall_o=1, counters unchanged.
//   - rd=x0 load never stalls. A store (rs2Used) after a load to the same rd does
//     stall.
// STRUCTURE
//   - Shared package core_pkg: opcode constants (OP_R 0110011, OP_I 0010011,
//     OP_LD 0000011, OP_ST 0100011, OP_BR 1100011), ALUOP_* 2-bit encodings,
//     ctrl bundle width.
//   - Sub-module hazard_detect: pure combinational haz term; everything else inline.
// TESTING
//   1. Reset mid-stream: assert rst_n_i=0 async while exValid_o=1
//      -> all outputs 0 in the same cycle, before any clock edge.
//   2. lw x5 then add x6,x5,x1 -> stall_o=1 for 1 cycle, one bubble
//      (exRegWrite_o=0), then add enters EX; stallCnt=1, bubbleCnt=1.
//   3. lw x0 then add x6,x0,x0 -> no stall; add reaches EX the next cycle.
//   4. lw x7 then beq x7,x2 with flush_i=1 -> flush_o=0 while stalled; next cycle
//      flush_o=1.
//   5. hold_i=1 for 3 cycles during a hazard -> ex*_o frozen, counters unchanged,
//      stall_o=1 throughout.
//   6. CNT_W=2 with 5 consecutive hazards -> stallCnt_o saturates at 3.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Definitions shared by the RV32 pipeline stages.
//   - OP_*     : 7-bit major opcodes of the supported instruction classes
//   - ALUOP_*  : 2-bit ALU-operation class produced by the Control unit
//   - ctrl_t   : control bundle that travels from ID into EX
//   - CTRL_W   : width of that bundle
//   - bubbleCtrl(): turns a control bundle into a harmless no-op bundle
// ---------------------------------------------------------------------------
package core_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrc;
        logic       wbDst;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regWrite;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // A bubble must not touch architectural state: no register write and no
    // memory access. aluSrc/wbDst are meaningless in a bubble, so they simply
    // keep their previous value instead of costing extra mux logic.
    function automatic ctrl_t bubbleCtrl(input ctrl_t c);
        ctrl_t b;
        b          = c;
        b.aluOp    = ALUOP_LDST;
        b.memRead  = 1'b0;
        b.memWrite = 1'b0;
        b.memToReg = 1'b0;
        b.regWrite = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Combinational load-use hazard term. A hazard exists when EX holds a real
//   load that writes a non-zero register and the real instruction in ID reads
//   that register through an operand it actually uses.
// Ports
//   exValid_i    EX holds a real instruction
//   exMemRead_i  EX instruction is a load
//   exRdAddr_i   EX destination register
//   valid_i      ID holds a real instruction
//   rs1Used_i / rs1Addr_i   ID reads rs1 / its index
//   rs2Used_i / rs2Addr_i   ID reads rs2 / its index
//   haz_o        load-use hazard
// ---------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              exValid_i,
    input  logic              exMemRead_i,
    input  logic [REG_AW-1:0] exRdAddr_i,
    input  logic              valid_i,
    input  logic              rs1Used_i,
    input  logic [REG_AW-1:0] rs1Addr_i,
    input  logic              rs2Used_i,
    input  logic [REG_AW-1:0] rs2Addr_i,
    output logic              haz_o
);

    logic loadInEx;
    logic rs1Match;
    logic rs2Match;

    // x0 is hard-wired to zero, so a load targeting it produces nothing to wait for.
    assign loadInEx = exValid_i & exMemRead_i & (exRdAddr_i != '0);
    assign rs1Match = rs1Used_i & (rs1Addr_i == exRdAddr_i);
    assign rs2Match = rs2Used_i & (rs2Addr_i == exRdAddr_i);
    assign haz_o    = loadInEx & valid_i & (rs1Match | rs2Match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage RV32 core. Captures the Control
//   bundle and the ID operands for EX, detects load-use hazards (stalling PC
//   and IF/ID and inserting one bubble), gates the branch flush while stalled
//   and keeps saturating stall/bubble performance counters.
// Ports
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   valid_i                   ID holds a real instruction
//   aluOp_i .. regWrite_i     Control-unit outputs
//   flush_i                   branch taken in ID
//   funct_i                   {funct7,funct3}
//   rs1Data_i, rs2Data_i      register-file read data
//   imm_i                     sign-extended immediate
//   rs1Addr_i/rs1Used_i, rs2Addr_i/rs2Used_i, rdAddr_i  register indices
//   hold_i                    freeze request from MEM
//   ex*_o                     registered copies for EX, exValid_o
//   stall_o                   hold PC and IF/ID (combinational)
//   flush_o                   gated flush to IF/ID (combinational)
//   stallCnt_o, bubbleCnt_o   saturating performance counters
// ---------------------------------------------------------------------------
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [1:0]        aluOp_i,
    input  logic              aluSrc_i,
    input  logic              wbDst_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic              memToReg_i,
    input  logic              regWrite_i,
    input  logic              flush_i,
    input  logic [9:0]        funct_i,
    input  logic [XLEN-1:0]   rs1Data_i,
    input  logic [XLEN-1:0]   rs2Data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [REG_AW-1:0] rs1Addr_i,
    input  logic              rs1Used_i,
    input  logic [REG_AW-1:0] rs2Addr_i,
    input  logic              rs2Used_i,
    input  logic [REG_AW-1:0] rdAddr_i,
    input  logic              hold_i,
    output logic [1:0]        exAluOp_o,
    output logic              exAluSrc_o,
    output logic              exWbDst_o,
    output logic              exMemRead_o,
    output logic              exMemWrite_o,
    output logic              exMemToReg_o,
    output logic              exRegWrite_o,
    output logic [9:0]        exFunct_o,
    output logic [XLEN-1:0]   exRs1Data_o,
    output logic [XLEN-1:0]   exRs2Data_o,
    output logic [XLEN-1:0]   exImm_o,
    output logic [REG_AW-1:0] exRs1Addr_o,
    output logic [REG_AW-1:0] exRs2Addr_o,
    output logic [REG_AW-1:0] exRdAddr_o,
    output logic              exValid_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  stallCnt_o,
    output logic [CNT_W-1:0]  bubbleCnt_o
);

    ctrl_t             inCtrl;
    ctrl_t             exCtrlReg;
    logic              exValidReg;
    logic [9:0]        exFunctReg;
    logic [XLEN-1:0]   exRs1DataReg;
    logic [XLEN-1:0]   exRs2DataReg;
    logic [XLEN-1:0]   exImmReg;
    logic [REG_AW-1:0] exRs1AddrReg;
    logic [REG_AW-1:0] exRs2AddrReg;
    logic [REG_AW-1:0] exRdAddrReg;

    logic haz;
    logic insertBubble;
    logic loadInstr;

    assign inCtrl.aluOp    = aluOp_i;
    assign inCtrl.aluSrc   = aluSrc_i;
    assign inCtrl.wbDst    = wbDst_i;
    assign inCtrl.memRead  = memRead_i;
    assign inCtrl.memWrite = memWrite_i;
    assign inCtrl.memToReg = memToReg_i;
    assign inCtrl.regWrite = regWrite_i;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) uHazardDetect (
        .exValid_i   (exValidReg),
        .exMemRead_i (exCtrlReg.memRead),
        .exRdAddr_i  (exRdAddrReg),
        .valid_i     (valid_i),
        .rs1Used_i   (rs1Used_i),
        .rs1Addr_i   (rs1Addr_i),
        .rs2Used_i   (rs2Used_i),
        .rs2Addr_i   (rs2Addr_i),
        .haz_o       (haz)
    );

    // A branch decided in ID while its operand is still being loaded used
    // stale data, so it must not redirect fetch; it re-resolves next cycle.
    assign stall_o = haz | hold_i;
    assign flush_o = flush_i & ~stall_o;

    // hold_i outranks everything: a frozen stage neither loads nor bubbles.
    assign insertBubble = ~hold_i & (haz | ~valid_i);
    assign loadInstr    = ~hold_i & ~haz & valid_i;

    // Control/valid half of the pipeline register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exValidReg <= 1'b0;
            exCtrlReg  <= '0;
        end else if (insertBubble) begin
            exValidReg <= 1'b0;
            exCtrlReg  <= bubbleCtrl(exCtrlReg);
        end else if (loadInstr) begin
            exValidReg <= 1'b1;
            exCtrlReg  <= inCtrl;
        end
    end

    // Data half: only written when a real instruction enters EX; a bubble
    // leaves the previous contents in place since nothing consumes them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exFunctReg   <= '0;
            exRs1DataReg <= '0;
            exRs2DataReg <= '0;
            exImmReg     <= '0;
            exRs1AddrReg <= '0;
            exRs2AddrReg <= '0;
            exRdAddrReg  <= '0;
        end else if (loadInstr) begin
            exFunctReg   <= funct_i;
            exRs1DataReg <= rs1Data_i;
            exRs2DataReg <= rs2Data_i;
            exImmReg     <= imm_i;
            exRs1AddrReg <= rs1Addr_i;
            exRs2AddrReg <= rs2Addr_i;
            exRdAddrReg  <= rdAddr_i;
        end
    end

    // Performance counters: index 0 counts load-use stall cycles, index 1
    // counts bubbles. Both stick at all-ones rather than wrapping.
    logic [1:0]       cntInc;
    logic [CNT_W-1:0] cntReg [2];

    assign cntInc[0] = haz & ~hold_i;
    assign cntInc[1] = insertBubble;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gCounter
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    cntReg[gi] <= '0;
                end else if (cntInc[gi] && (cntReg[gi] != {CNT_W{1'b1}})) begin
                    cntReg[gi] <= cntReg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stallCnt_o  = cntReg[0];
    assign bubbleCnt_o = cntReg[1];

    assign exAluOp_o    = exCtrlReg.aluOp;
    assign exAluSrc_o   = exCtrlReg.aluSrc;
    assign exWbDst_o    = exCtrlReg.wbDst;
    assign exMemRead_o  = exCtrlReg.memRead;
    assign exMemWrite_o = exCtrlReg.memWrite;
    assign exMemToReg_o = exCtrlReg.memToReg;
    assign exRegWrite_o = exCtrlReg.regWrite;
    assign exFunct_o    = exFunctReg;
    assign exRs1Data_o  = exRs1DataReg;
    assign exRs2Data_o  = exRs2DataReg;
    assign exImm_o      = exImmReg;
    assign exRs1Addr_o  = exRs1AddrReg;
    assign exRs2Addr_o  = exRs2AddrReg;
    assign exRdAddr_o   = exRdAddrReg;
    assign exValid_o    = exValidReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. Two instances share all inputs: one
//   with 16-bit counters and one with 2-bit counters to reach saturation.
//   The reference keeps the instruction currently in EX as a plain record
//   and true (unbounded) stall/bubble counts, saturating only when compared.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluOp;
        logic        aluSrc;
        logic        wbDst;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        regWrite;
        logic [9:0]  funct;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } rec_t;

    localparam int K_LD = 0, K_R = 1, K_I = 2, K_ST = 3, K_BR = 4;

    logic clk_i = 1'b0;
    logic rst_n_i;
    rec_t cur;
    logic curRs1Used, curRs2Used, curFlush, curHold;

    logic [1:0]  exAluOp_o;
    logic        exAluSrc_o, exWbDst_o, exMemRead_o, exMemWrite_o, exMemToReg_o, exRegWrite_o;
    logic [9:0]  exFunct_o;
    logic [31:0] exRs1Data_o, exRs2Data_o, exImm_o;
    logic [4:0]  exRs1Addr_o, exRs2Addr_o, exRdAddr_o;
    logic        exValid_o, stall_o, flush_o;
    logic [15:0] stallCnt_o, bubbleCnt_o;

    logic [1:0]  nAluOp;
    logic        nAluSrc, nWbDst, nMemRead, nMemWrite, nMemToReg, nRegWrite;
    logic [9:0]  nFunct;
    logic [31:0] nRs1Data, nRs2Data, nImm;
    logic [4:0]  nRs1Addr, nRs2Addr, nRdAddr;
    logic        nValid, nStall, nFlush;
    logic [1:0]  nStallCnt, nBubbleCnt;

    int checks = 0;
    int errors = 0;

    rec_t mEx;
    int   mStall;
    int   mBubble;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(cur.valid),
        .aluOp_i(cur.aluOp), .aluSrc_i(cur.aluSrc), .wbDst_i(cur.wbDst),
        .memRead_i(cur.memRead), .memWrite_i(cur.memWrite), .memToReg_i(cur.memToReg),
        .regWrite_i(cur.regWrite), .flush_i(curFlush), .funct_i(cur.funct),
        .rs1Data_i(cur.rs1Data), .rs2Data_i(cur.rs2Data), .imm_i(cur.imm),
        .rs1Addr_i(cur.rs1), .rs1Used_i(curRs1Used), .rs2Addr_i(cur.rs2),
        .rs2Used_i(curRs2Used), .rdAddr_i(cur.rd), .hold_i(curHold),
        .exAluOp_o(exAluOp_o), .exAluSrc_o(exAluSrc_o), .exWbDst_o(exWbDst_o),
        .exMemRead_o(exMemRead_o), .exMemWrite_o(exMemWrite_o), .exMemToReg_o(exMemToReg_o),
        .exRegWrite_o(exRegWrite_o), .exFunct_o(exFunct_o), .exRs1Data_o(exRs1Data_o),
        .exRs2Data_o(exRs2Data_o), .exImm_o(exImm_o), .exRs1Addr_o(exRs1Addr_o),
        .exRs2Addr_o(exRs2Addr_o), .exRdAddr_o(exRdAddr_o), .exValid_o(exValid_o),
        .stall_o(stall_o), .flush_o(flush_o), .stallCnt_o(stallCnt_o), .bubbleCnt_o(bubbleCnt_o)
    );

    id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(2)) dutNarrow (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(cur.valid),
        .aluOp_i(cur.aluOp), .aluSrc_i(cur.aluSrc), .wbDst_i(cur.wbDst),
        .memRead_i(cur.memRead), .memWrite_i(cur.memWrite), .memToReg_i(cur.memToReg),
        .regWrite_i(cur.regWrite), .flush_i(curFlush), .funct_i(cur.funct),
        .rs1Data_i(cur.rs1Data), .rs2Data_i(cur.rs2Data), .imm_i(cur.imm),
        .rs1Addr_i(cur.rs1), .rs1Used_i(curRs1Used), .rs2Addr_i(cur.rs2),
        .rs2Used_i(curRs2Used), .rdAddr_i(cur.rd), .hold_i(curHold),
        .exAluOp_o(nAluOp), .exAluSrc_o(nAluSrc), .exWbDst_o(nWbDst),
        .exMemRead_o(nMemRead), .exMemWrite_o(nMemWrite), .exMemToReg_o(nMemToReg),
        .exRegWrite_o(nRegWrite), .exFunct_o(nFunct), .exRs1Data_o(nRs1Data),
        .exRs2Data_o(nRs2Data), .exImm_o(nImm), .exRs1Addr_o(nRs1Addr),
        .exRs2Addr_o(nRs2Addr), .exRdAddr_o(nRdAddr), .exValid_o(nValid),
        .stall_o(nStall), .flush_o(nFlush), .stallCnt_o(nStallCnt), .bubbleCnt_o(nBubbleCnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int maxVal);
        return (n > maxVal) ? maxVal : n;
    endfunction

    // Load-use rule stated directly on the instruction in EX and the one in ID.
    function automatic logic modelHaz();
        if (!(mEx.valid && mEx.memRead && mEx.rd != 5'd0 && cur.valid)) return 1'b0;
        return (curRs1Used && cur.rs1 == mEx.rd) || (curRs2Used && cur.rs2 == mEx.rd);
    endfunction

    task automatic setInstr(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2);
        cur = '0;
        cur.valid   = 1'b1;
        cur.rd      = rd;
        cur.rs1     = rs1;
        cur.rs2     = rs2;
        cur.wbDst   = 1'($urandom_range(0, 1));
        cur.funct   = 10'($urandom);
        cur.rs1Data = $urandom;
        cur.rs2Data = $urandom;
        cur.imm     = $urandom;
        curRs1Used  = 1'b1;
        curRs2Used  = 1'b0;
        curFlush    = 1'b0;
        curHold     = 1'b0;
        case (kind)
            K_LD: begin cur.aluOp = 2'b00; cur.aluSrc = 1'b1; cur.memRead = 1'b1;
                        cur.memToReg = 1'b1; cur.regWrite = 1'b1; end
            K_R:  begin cur.aluOp = 2'b10; cur.regWrite = 1'b1; curRs2Used = 1'b1; end
            K_I:  begin cur.aluOp = 2'b01; cur.aluSrc = 1'b1; cur.regWrite = 1'b1; end
            K_ST: begin cur.aluOp = 2'b00; cur.aluSrc = 1'b1; cur.memWrite = 1'b1;
                        curRs2Used = 1'b1; end
            default: begin cur.aluOp = 2'b01; curRs2Used = 1'b1; end
        endcase
    endtask

    task automatic checkEx(input string tag);
        chk({tag, "_valid"},    64'(exValid_o),    64'(mEx.valid));
        chk({tag, "_regWrite"}, 64'(exRegWrite_o), 64'(mEx.regWrite));
        chk({tag, "_memRead"},  64'(exMemRead_o),  64'(mEx.memRead));
        chk({tag, "_memWrite"}, 64'(exMemWrite_o), 64'(mEx.memWrite));
        chk({tag, "_memToReg"}, 64'(exMemToReg_o), 64'(mEx.memToReg));
        chk({tag, "_aluOp"},    64'(exAluOp_o),    64'(mEx.aluOp));
        if (mEx.valid) begin
            chk({tag, "_aluSrc"},  64'(exAluSrc_o),  64'(mEx.aluSrc));
            chk({tag, "_wbDst"},   64'(exWbDst_o),   64'(mEx.wbDst));
            chk({tag, "_funct"},   64'(exFunct_o),   64'(mEx.funct));
            chk({tag, "_rs1Data"}, 64'(exRs1Data_o), 64'(mEx.rs1Data));
            chk({tag, "_rs2Data"}, 64'(exRs2Data_o), 64'(mEx.rs2Data));
            chk({tag, "_imm"},     64'(exImm_o),     64'(mEx.imm));
            chk({tag, "_rs1"},     64'(exRs1Addr_o), 64'(mEx.rs1));
            chk({tag, "_rs2"},     64'(exRs2Addr_o), 64'(mEx.rs2));
            chk({tag, "_rd"},      64'(exRdAddr_o),  64'(mEx.rd));
        end
        chk({tag, "_stallCnt"},   64'(stallCnt_o),  64'(sat(mStall, 65535)));
        chk({tag, "_bubbleCnt"},  64'(bubbleCnt_o), 64'(sat(mBubble, 65535)));
        chk({tag, "_nValid"},     64'(nValid),      64'(mEx.valid));
        chk({tag, "_nStallCnt"},  64'(nStallCnt),   64'(sat(mStall, 3)));
        chk({tag, "_nBubbleCnt"}, 64'(nBubbleCnt),  64'(sat(mBubble, 3)));
    endtask

    // One clock cycle with the currently driven ID inputs.
    task automatic step(input string tag);
        logic h;
        h = modelHaz();
        #1;
        chk({tag, "_stall"},  64'(stall_o), 64'(h | curHold));
        chk({tag, "_flush"},  64'(flush_o), 64'(curFlush & ~(h | curHold)));
        chk({tag, "_nStall"}, 64'(nStall),  64'(h | curHold));
        @(posedge clk_i);
        if (!curHold) begin
            if (h || !cur.valid) begin
                mEx.valid    = 1'b0;
                mEx.regWrite = 1'b0;
                mEx.memRead  = 1'b0;
                mEx.memWrite = 1'b0;
                mEx.memToReg = 1'b0;
                mEx.aluOp    = 2'b00;
                if (h) mStall++;
                mBubble++;
            end else begin
                mEx = cur;
            end
        end
        #1;
        checkEx(tag);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_valid"},   64'(exValid_o),   64'(0));
        chk({tag, "_ctrl"},    64'({exAluOp_o, exAluSrc_o, exWbDst_o, exMemRead_o, exMemWrite_o,
                                    exMemToReg_o, exRegWrite_o}), 64'(0));
        chk({tag, "_funct"},   64'(exFunct_o),   64'(0));
        chk({tag, "_data"},    64'(exRs1Data_o | exRs2Data_o | exImm_o), 64'(0));
        chk({tag, "_addr"},    64'({exRs1Addr_o, exRs2Addr_o, exRdAddr_o}), 64'(0));
        chk({tag, "_cnt"},     64'({stallCnt_o, bubbleCnt_o}), 64'(0));
        chk({tag, "_nCnt"},    64'({nValid, nStallCnt, nBubbleCnt}), 64'(0));
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next edge.
    task automatic midReset(input string tag);
        rst_n_i = 1'b0;
        #1;
        checkAllZero(tag);
        mEx = '0; mStall = 0; mBubble = 0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        cur = '0; curRs1Used = 0; curRs2Used = 0; curFlush = 0; curHold = 0;
        mEx = '0; mStall = 0; mBubble = 0;
        #22;
        checkAllZero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // lw x5 ; add x6,x5,x1 : one stall, one bubble, then add enters EX
        setInstr(K_LD, 5'd5, 5'd1, 5'd0); step("t2_lw");
        setInstr(K_R, 5'd6, 5'd5, 5'd1);
        #1 chk("t2_stall_now", 64'(stall_o), 64'(1));
        step("t2_haz");
        chk("t2_bubble_regWrite", 64'(exRegWrite_o), 64'(0));
        step("t2_add");
        chk("t2_add_rd", 64'(exRdAddr_o), 64'(6));
        chk("t2_stallCnt", 64'(stallCnt_o), 64'(1));
        chk("t2_bubbleCnt", 64'(bubbleCnt_o), 64'(1));

        // asynchronous reset while EX holds the add
        chk("t1_pre_valid", 64'(exValid_o), 64'(1));
        midReset("t1_async");

        // lw x0 ; add x6,x0,x0 : no stall
        setInstr(K_LD, 5'd0, 5'd2, 5'd0); step("t3_lw0");
        setInstr(K_R, 5'd6, 5'd0, 5'd0);
        #1 chk("t3_no_stall", 64'(stall_o), 64'(0));
        step("t3_add");
        chk("t3_add_valid", 64'(exValid_o), 64'(1));
        chk("t3_add_rd", 64'(exRdAddr_o), 64'(6));

        // lw x7 ; beq x7,x2 with taken flush: gated while stalled
        setInstr(K_LD, 5'd7, 5'd3, 5'd0); step("t4_lw");
        setInstr(K_BR, 5'd0, 5'd7, 5'd2); curFlush = 1'b1;
        #1 chk("t4_flush_gated", 64'(flush_o), 64'(0));
        step("t4_beq_stall");
        #1 chk("t4_flush_pass", 64'(flush_o), 64'(1));
        step("t4_beq_go");

        // store using a just-loaded rs2 also stalls
        setInstr(K_LD, 5'd8, 5'd1, 5'd0); step("st_lw");
        setInstr(K_ST, 5'd0, 5'd1, 5'd8);
        #1 chk("st_stall", 64'(stall_o), 64'(1));
        step("st_haz");
        step("st_go");

        // hold for 3 cycles during a hazard
        setInstr(K_LD, 5'd9, 5'd1, 5'd0); step("t5_lw");
        setInstr(K_R, 5'd3, 5'd9, 5'd4);
        curHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_hold_stall", 64'(stall_o), 64'(1));
            step("t5_hold");
        end
        chk("t5_frozen_rd", 64'(exRdAddr_o), 64'(9));
        curHold = 1'b0;
        step("t5_haz");
        step("t5_add");

        // five back-to-back load-use pairs: 2-bit counter sticks at 3
        midReset("t6_reset");
        for (int i = 0; i < 5; i++) begin
            setInstr(K_LD, 5'd5, 5'd1, 5'd0); step("t6_lw");
            setInstr(K_R, 5'd6, 5'd5, 5'd5); step("t6_haz");
            step("t6_add");
        end
        chk("t6_narrow_sat", 64'(nStallCnt), 64'(3));
        chk("t6_wide_cnt", 64'(stallCnt_o), 64'(5));

        // randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = int'($urandom_range(0, 4));
            setInstr(kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)));
            cur.valid = ($urandom_range(0, 9) < 8);
            curFlush  = (kind == K_BR) ? 1'($urandom_range(0, 1)) : 1'b0;
            curHold   = ($urandom_range(0, 6) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
